ps2_frame_rx: RTL



---
 rtl/ps2_frame_rx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame receiver: synchronises ps2Clk/ps2Data, times each clock phase and assembles 11-bit frames.
// Optional odd-parity fault checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_frame_rx #(
  parameter int unsigned counterBits = 8,
  parameter int unsigned minClk      = 15,
  parameter int unsigned maxClk      = 25,
  parameter int unsigned readAt      = 5,
  parameter int unsigned timeoutClk  = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] data,
  output logic       dataReady,
  output logic       error
);

  localparam logic [counterBits-1:0] MIN_C     = counterBits'(minClk);
  localparam logic [counterBits-1:0] MAX_C     = counterBits'(maxClk);
  localparam logic [counterBits-1:0] READ_AT   = counterBits'(readAt);
  localparam logic [counterBits-1:0] TIMEOUT_C = counterBits'(timeoutClk);
  localparam logic [3:0]             LAST_BIT  = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_e;

  state_e                 state_q;
  logic [counterBits-1:0] cnt_q;
  logic [3:0]             idx_q;
  logic [10:0]            frame_q;
  logic                   clk_s1_q, clk_s2_q, clk_prev_q;
  logic                   dat_s1_q, dat_s2_q;
  logic                   eval_q;
  logic [7:0]             data_q;
  logic                   ready_q;
  logic                   error_q;

  logic                   fall_c;
  logic [counterBits-1:0] cnt_inc_c;
  logic                   parity_ok_c;
  logic                   frame_ok_c;

  assign fall_c    = clk_prev_q & ~clk_s2_q;
  assign cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + counterBits'(1);

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok_c = ^frame_q[9:1];
`else
  logic unused_parity_c;
  assign unused_parity_c = frame_q[9];
  assign parity_ok_c     = 1'b1;
`endif

  assign frame_ok_c = ~frame_q[0] & frame_q[10] & parity_ok_c;

  // Phase-timing FSM; frame evaluation runs one cycle after the stop bit while already back in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      eval_q     <= 1'b0;
      data_q     <= 8'h00;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      clk_s1_q   <= ps2Clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2Data;
      dat_s2_q   <= dat_s1_q;
      ready_q    <= 1'b0;
      eval_q     <= 1'b0;

      if (eval_q) begin
        if (frame_ok_c) begin
          data_q  <= frame_q[8:1];
          ready_q <= 1'b1;
          error_q <= 1'b0;
        end else begin
          error_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (fall_c) begin
            state_q <= S_LOW;
            idx_q   <= '0;
            cnt_q   <= '0;
          end
        end
        S_LOW: begin
          if (clk_s2_q) begin
            cnt_q <= '0;
            if (cnt_q < MIN_C) begin
              error_q <= 1'b1;
              state_q <= S_IDLE;
            end else if (idx_q == LAST_BIT) begin
              eval_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_HIGH;
            end
          end else if (cnt_q == MAX_C) begin
            error_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc_c;
            if (cnt_q == READ_AT) begin
              frame_q[idx_q] <= dat_s2_q;
              // A high start bit aborts at once; later edges restart framing from IDLE.
              if (idx_q == 4'd0 && dat_s2_q) begin
                error_q <= 1'b1;
                state_q <= S_IDLE;
                cnt_q   <= '0;
              end
            end
          end
        end
        S_HIGH: begin
          if (fall_c) begin
            state_q <= S_LOW;
            idx_q   <= idx_q + 4'd1;
            cnt_q   <= '0;
          end else if (cnt_q == TIMEOUT_C) begin
            error_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc_c;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign dataReady = ready_q;
  assign error     = error_q;

endmodule
